// File: rtl/bubsysrom_pkg.sv
// -----------------------------------------------------------------------------
// bubsysrom_pkg
// Shared definitions for the Bubble System ROM loader:
//   loader_state_t    - loader FSM states
//   ROM_INDEX_DEFAULT - ioctl index that carries the ROM image
//   SDRAM_AW          - SDRAM word address width
//   wordAddr()        - maps an ioctl word offset onto the SDRAM word space
// -----------------------------------------------------------------------------
package bubsysrom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HAVE_HI = 2'd1,
    ST_REQ     = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_t;

  localparam logic [15:0] ROM_INDEX_DEFAULT = 16'h0000;
  localparam int          SDRAM_AW          = 24;

  // The sum is deliberately truncated to the SDRAM address width so an image
  // placed near the top of memory wraps around to address 0.
  function automatic logic [SDRAM_AW-1:0] wordAddr(
    input logic [SDRAM_AW-1:0] base,
    input logic [SDRAM_AW-1:0] wordOffset
  );
    return base + wordOffset;
  endfunction

endpackage

// File: rtl/bubsysrom_rom_loader.sv
// -----------------------------------------------------------------------------
// bubsysrom_rom_loader
// Packs the byte stream of an ioctl ROM download into big-endian (68000 order)
// 16-bit SDRAM writes and flags when the whole image is in memory.
//
// Parameters
//   ROM_INDEX  - ioctl_index value treated as the ROM download
//   SDRAM_BASE - SDRAM word address that ioctl byte 0 lands on
//
// Ports
//   i_EMU_MCLK          clock (72 MHz), rising edge
//   i_EMU_INITRST       asynchronous active-high reset
//   i_IOCTL_INDEX       download image index
//   i_IOCTL_DOWNLOAD    download window active
//   i_IOCTL_ADDR        byte address
//   i_IOCTL_DATA        byte data
//   i_IOCTL_WR          one-cycle byte strobe
//   o_IOCTL_WAIT        stalls the ioctl source
//   o_SDRAM_WR_REQ      write request, held until acknowledged
//   o_SDRAM_ADDR        SDRAM word address
//   o_SDRAM_DATA        SDRAM write word
//   o_SDRAM_BE          byte enables {hi,lo}
//   i_SDRAM_WR_ACK      one-cycle write completion
//   o_ROM_DOWNLOAD_DONE ROM image fully written
//   o_CHECKSUM          16-bit sum of accepted ROM bytes
//                       (only when BUBSYSROM_LOADER_CHECKSUM_EN is defined)
// -----------------------------------------------------------------------------
module bubsysrom_rom_loader
  import bubsysrom_pkg::*;
#(
  parameter logic [15:0]         ROM_INDEX  = ROM_INDEX_DEFAULT,
  parameter logic [SDRAM_AW-1:0] SDRAM_BASE = 24'h000000
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_INITRST,
  input  logic [15:0]         i_IOCTL_INDEX,
  input  logic                i_IOCTL_DOWNLOAD,
  input  logic [26:0]         i_IOCTL_ADDR,
  input  logic [7:0]          i_IOCTL_DATA,
  input  logic                i_IOCTL_WR,
  output logic                o_IOCTL_WAIT,
  output logic                o_SDRAM_WR_REQ,
  output logic [SDRAM_AW-1:0] o_SDRAM_ADDR,
  output logic [15:0]         o_SDRAM_DATA,
  output logic [1:0]          o_SDRAM_BE,
  input  logic                i_SDRAM_WR_ACK,
  output logic                o_ROM_DOWNLOAD_DONE
`ifdef BUBSYSROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]         o_CHECKSUM
`endif
);

  loader_state_t r_state;
  loader_state_t w_nextState;

  logic                r_dlPrev;
  logic                r_dlEnded;
  logic [SDRAM_AW-1:0] r_addr;
  logic [15:0]         r_data;
  logic [1:0]          r_be;
  logic                r_pend;
  logic                r_pendOdd;
  logic [7:0]          r_pendData;
  logic [SDRAM_AW-1:0] r_pendAddr;

  logic                w_romDl;
  logic                w_accept;
  logic                w_rise;
  logic                w_fall;
  logic                w_dlEndedNow;
  logic                w_odd;
  logic [SDRAM_AW-1:0] w_wordAddr;
  logic                w_sameWord;
  logic                w_unused;

  assign w_romDl    = i_IOCTL_DOWNLOAD && (i_IOCTL_INDEX == ROM_INDEX);
  assign w_accept   = i_IOCTL_WR && w_romDl;
  assign w_rise     = w_romDl && !r_dlPrev;
  assign w_fall     = !w_romDl && r_dlPrev;
  // A stale "ended" flag must not count in the cycle a new download opens.
  assign w_dlEndedNow = (r_dlEnded && !w_rise) || w_fall;
  assign w_odd      = i_IOCTL_ADDR[0];
  assign w_wordAddr = wordAddr(SDRAM_BASE, i_IOCTL_ADDR[24:1]);
  assign w_sameWord = (w_wordAddr == r_addr);
  // Bits above the 16M-word space are architecturally ignored.
  assign w_unused   = ^i_IOCTL_ADDR[26:25];

  // Track the ROM download window so its opening and closing edges can be
  // seen; the "ended" flag remembers a close that happened while a write was
  // still in flight so DONE is reached once that write retires.
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      r_dlPrev  <= 1'b0;
      r_dlEnded <= 1'b0;
    end else begin
      r_dlPrev <= w_romDl;
      if (w_rise)
        r_dlEnded <= 1'b0;
      else if (w_fall)
        r_dlEnded <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST)
      r_state <= ST_IDLE;
    else
      r_state <= w_nextState;
  end

  // Next-state logic. A byte that cannot join the held high byte forces a
  // flush and is parked; after the ack it is treated as if it had just arrived
  // in IDLE, so an odd parked byte goes straight back to REQ rather than
  // masquerading as a high byte in HAVE_HI. A strobe in the very first cycle
  // of a new download is honoured even while leaving DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_nextState = w_odd ? ST_REQ : ST_HAVE_HI;
        else if (w_dlEndedNow)
          w_nextState = ST_DONE;
      end
      ST_HAVE_HI: begin
        if (w_accept || w_dlEndedNow)
          w_nextState = ST_REQ;
      end
      ST_REQ: begin
        if (i_SDRAM_WR_ACK) begin
          if (r_pend)
            w_nextState = r_pendOdd ? ST_REQ : ST_HAVE_HI;
          else if (w_dlEndedNow)
            w_nextState = ST_DONE;
          else
            w_nextState = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (w_accept)
          w_nextState = w_odd ? ST_REQ : ST_HAVE_HI;
        else if (w_rise)
          w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // FSM outputs. Wait covers the whole request plus any parked byte so the
  // source never presents a byte we have no room for.
  always_comb begin
    o_SDRAM_WR_REQ      = (r_state == ST_REQ);
    o_IOCTL_WAIT        = (r_state == ST_REQ) || r_pend;
    o_ROM_DOWNLOAD_DONE = (r_state == ST_DONE);
  end

  // Write datapath. Address, data and byte enables only change on the cycle
  // that enters REQ (or latches a high byte), so they are stable for the whole
  // request. In HAVE_HI the low data byte is always zero, so a flush only needs
  // its byte enables narrowed to the high lane.
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_be       <= '0;
      r_pend     <= 1'b0;
      r_pendOdd  <= 1'b0;
      r_pendData <= '0;
      r_pendAddr <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_addr <= w_wordAddr;
            if (w_odd) begin
              r_data <= {8'h00, i_IOCTL_DATA};
              r_be   <= 2'b01;
            end else begin
              r_data <= {i_IOCTL_DATA, 8'h00};
              r_be   <= 2'b10;
            end
          end
        end
        ST_HAVE_HI: begin
          if (w_accept) begin
            if (w_odd && w_sameWord) begin
              r_data[7:0] <= i_IOCTL_DATA;
              r_be        <= 2'b11;
            end else begin
              r_be       <= 2'b10;
              r_pend     <= 1'b1;
              r_pendOdd  <= w_odd;
              r_pendData <= i_IOCTL_DATA;
              r_pendAddr <= w_wordAddr;
            end
          end else if (w_dlEndedNow) begin
            r_be <= 2'b10;
          end
        end
        ST_REQ: begin
          if (i_SDRAM_WR_ACK && r_pend) begin
            r_pend <= 1'b0;
            r_addr <= r_pendAddr;
            if (r_pendOdd) begin
              r_data <= {8'h00, r_pendData};
              r_be   <= 2'b01;
            end else begin
              r_data <= {r_pendData, 8'h00};
              r_be   <= 2'b10;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_SDRAM_ADDR = r_addr;
  assign o_SDRAM_DATA = r_data;
  assign o_SDRAM_BE   = r_be;

`ifdef BUBSYSROM_LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Running sum of accepted ROM bytes, restarted whenever a new download opens
  // (including a byte that arrives in that same opening cycle).
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST)
      r_checksum <= '0;
    else if (w_rise)
      r_checksum <= w_accept ? {8'h00, i_IOCTL_DATA} : 16'h0000;
    else if (w_accept)
      r_checksum <= r_checksum + {8'h00, i_IOCTL_DATA};
  end

  assign o_CHECKSUM = r_checksum;
`endif

endmodule

// File: tb/tb_bubsysrom_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_bubsysrom_rom_loader
// Self-checking bench for bubsysrom_rom_loader. Two instances share the ioctl
// side: dut0 uses the default SDRAM_BASE, dut1 uses SDRAM_BASE=0x100000 and is
// normally parked on an unused index. Expected SDRAM writes are queued per
// instance and compared when the write handshake happens.
// Define BUBSYSROM_LOADER_CHECKSUM_EN to also exercise o_CHECKSUM.
// -----------------------------------------------------------------------------
module tb_bubsysrom_rom_loader;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] idx = 16'h0000;
  logic [15:0] idx1 = 16'hFFFF;
  logic        dl = 1'b0;
  logic [26:0] addr = '0;
  logic [7:0]  data = '0;
  logic        wr = 1'b0;

  logic        wait0, req0, done0, ack0;
  logic [23:0] sAddr0;
  logic [15:0] sData0;
  logic [1:0]  sBe0;
  logic        wait1, req1, done1, ack1;
  logic [23:0] sAddr1;
  logic [15:0] sData1;
  logic [1:0]  sBe1;
`ifdef BUBSYSROM_LOADER_CHECKSUM_EN
  logic [15:0] csum0, csum1;
`endif

  logic ackAuto0 = 1'b0, ackForce0 = 1'b0, ackAuto1 = 1'b0;
  bit   ackEn0 = 1'b1;
  int   ackDelay0 = 1, ackDelay1 = 1;
  int   reqAge0 = 0, reqAge1 = 0;

  int   checkCount = 0;
  int   errorCount = 0;

  wr_t  q0[$];
  wr_t  q1[$];

  assign ack0 = ackAuto0 | ackForce0;
  assign ack1 = ackAuto1;

  always #5 clk = ~clk;

  bubsysrom_rom_loader dut0 (
    .i_EMU_MCLK(clk), .i_EMU_INITRST(rst),
    .i_IOCTL_INDEX(idx), .i_IOCTL_DOWNLOAD(dl), .i_IOCTL_ADDR(addr),
    .i_IOCTL_DATA(data), .i_IOCTL_WR(wr), .o_IOCTL_WAIT(wait0),
    .o_SDRAM_WR_REQ(req0), .o_SDRAM_ADDR(sAddr0), .o_SDRAM_DATA(sData0),
    .o_SDRAM_BE(sBe0), .i_SDRAM_WR_ACK(ack0), .o_ROM_DOWNLOAD_DONE(done0)
`ifdef BUBSYSROM_LOADER_CHECKSUM_EN
    , .o_CHECKSUM(csum0)
`endif
  );

  bubsysrom_rom_loader #(.ROM_INDEX(16'h0000), .SDRAM_BASE(24'h100000)) dut1 (
    .i_EMU_MCLK(clk), .i_EMU_INITRST(rst),
    .i_IOCTL_INDEX(idx1), .i_IOCTL_DOWNLOAD(dl), .i_IOCTL_ADDR(addr),
    .i_IOCTL_DATA(data), .i_IOCTL_WR(wr), .o_IOCTL_WAIT(wait1),
    .o_SDRAM_WR_REQ(req1), .o_SDRAM_ADDR(sAddr1), .o_SDRAM_DATA(sData1),
    .o_SDRAM_BE(sBe1), .i_SDRAM_WR_ACK(ack1), .o_ROM_DOWNLOAD_DONE(done1)
`ifdef BUBSYSROM_LOADER_CHECKSUM_EN
    , .o_CHECKSUM(csum1)
`endif
  );

  // SDRAM controller model for dut0: acks a request after it has been high
  // for ackDelay0 cycles; can be disabled to leave a request hanging.
  initial begin
    forever begin
      @(posedge clk); #1;
      ackAuto0 = 1'b0;
      if (ackEn0 && req0) begin
        reqAge0++;
        if (reqAge0 >= ackDelay0) begin
          ackAuto0 = 1'b1;
          reqAge0  = 0;
        end
      end else begin
        reqAge0 = 0;
      end
    end
  end

  // SDRAM controller model for dut1.
  initial begin
    forever begin
      @(posedge clk); #1;
      ackAuto1 = 1'b0;
      if (req1) begin
        reqAge1++;
        if (reqAge1 >= ackDelay1) begin
          ackAuto1 = 1'b1;
          reqAge1  = 0;
        end
      end else begin
        reqAge1 = 0;
      end
    end
  end

  // Scoreboard for dut0: every accepted write is matched against the oldest
  // expected write.
  always @(negedge clk) begin
    if (req0 && ack0) begin
      checkCount++;
      if (q0.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL dut0_write: unexpected write addr=%h data=%h be=%b, none expected",
                 sAddr0, sData0, sBe0);
      end else begin
        wr_t e;
        e = q0.pop_front();
        if ({sAddr0, sData0, sBe0} !== e) begin
          errorCount++;
          $display("[TB] FAIL dut0_write: got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                   sAddr0, sData0, sBe0, e.addr, e.data, e.be);
        end
      end
    end
  end

  // Scoreboard for dut1.
  always @(negedge clk) begin
    if (req1 && ack1) begin
      checkCount++;
      if (q1.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL dut1_write: unexpected write addr=%h data=%h be=%b, none expected",
                 sAddr1, sData1, sBe1);
      end else begin
        wr_t e;
        e = q1.pop_front();
        if ({sAddr1, sData1, sBe1} !== e) begin
          errorCount++;
          $display("[TB] FAIL dut1_write: got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                   sAddr1, sData1, sBe1, e.addr, e.data, e.be);
        end
      end
    end
  end

  // Watchdog so a wedged design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time=%0t, expected finish before limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one byte, honouring o_IOCTL_WAIT. Called at posedge+1, returns at
  // posedge+1 after the strobe has been sampled.
  task automatic applyStimulus(input logic [26:0] a, input logic [7:0] d);
    int n = 0;
    while ((wait0 || wait1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL wait_release: wait still high after %0d cycles, expected low", n);
    end
    addr = a;
    data = d;
    wr   = 1'b1;
    @(posedge clk); #1;
    wr   = 1'b0;
  endtask

  task automatic setDownload(input logic v);
    dl = v;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if ({req0, wait0, done0, sAddr0, sData0, sBe0} !== 45'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_outputs: req=%b wait=%b done=%b addr=%h data=%h be=%b, expected all zero",
               req0, wait0, done0, sAddr0, sData0, sBe0);
    end
    checkCount++;
    if ({req1, wait1, done1} !== 3'b000) begin
      errorCount++;
      $display("[TB] FAIL reset_dut1: req=%b wait=%b done=%b, expected 000", req1, wait1, done1);
    end
`ifdef BUBSYSROM_LOADER_CHECKSUM_EN
    checkCount++;
    if (csum0 !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL reset_checksum: got %h, expected 0000", csum0);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrong_index();
    int reqCnt = 0;
    idx = 16'h0001;
    setDownload(1'b1);
    applyStimulus(27'd0, 8'h11);
    applyStimulus(27'd1, 8'h22);
    applyStimulus(27'd2, 8'h33);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req0) reqCnt++;
    end
    @(posedge clk); #1;
    checkCount++;
    if (reqCnt !== 0) begin
      errorCount++;
      $display("[TB] FAIL wrong_index_req: saw %0d request cycles, expected 0", reqCnt);
    end
    setDownload(1'b0);
    idx = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (done0 !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL wrong_index_done: done=%b, expected 0", done0);
    end
  endtask

  task automatic test_pair();
    int waitCnt = 0;
    int reqCnt  = 0;
    ackDelay0 = 3;
    setDownload(1'b1);
    q0.push_back('{addr: 24'h000000, data: 16'h1234, be: 2'b11});
    applyStimulus(27'd0, 8'h12);
    applyStimulus(27'd1, 8'h34);
    @(negedge clk);
    checkCount++;
    if (req0 !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL odd_latency: req=%b one cycle after odd strobe, expected 1", req0);
    end
    if (req0) reqCnt++;
    if (wait0) waitCnt++;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (req0) reqCnt++;
      if (wait0) waitCnt++;
    end
    checkCount++;
    if (waitCnt !== 3) begin
      errorCount++;
      $display("[TB] FAIL pair_wait_cycles: got %0d, expected 3", waitCnt);
    end
    checkCount++;
    if (reqCnt !== 3) begin
      errorCount++;
      $display("[TB] FAIL pair_req_cycles: got %0d, expected 3", reqCnt);
    end
    @(posedge clk); #1;
    setDownload(1'b0);
    checkCount++;
    if (done0 !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL pair_done: done=%b after download fell, expected 1", done0);
    end
    ackDelay0 = 1;
  endtask

  task automatic test_odd_length();
    int n = 0;
    setDownload(1'b1);
    checkCount++;
    if (done0 !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL restart_clears_done: done=%b after new download, expected 0", done0);
    end
    q0.push_back('{addr: 24'h000000, data: 16'hAABB, be: 2'b11});
    q0.push_back('{addr: 24'h000001, data: 16'hCC00, be: 2'b10});
    applyStimulus(27'd0, 8'hAA);
    applyStimulus(27'd1, 8'hBB);
    applyStimulus(27'd2, 8'hCC);
    setDownload(1'b0);
    checkCount++;
    if (done0 !== 1'b0 || req0 !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL odd_flush_start: done=%b req=%b, expected done=0 req=1", done0, req0);
    end
    while (!done0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkCount++;
    if (done0 !== 1'b1 || q0.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL odd_length_done: done=%b pending_writes=%0d, expected done=1 pending=0",
               done0, q0.size());
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    ackDelay0 = 2;
    setDownload(1'b1);
    q0.push_back('{addr: 24'h000002, data: 16'h1100, be: 2'b10});
    q0.push_back('{addr: 24'h000003, data: 16'h2200, be: 2'b10});
    q0.push_back('{addr: 24'h000004, data: 16'h0033, be: 2'b01});
    q0.push_back('{addr: 24'h000005, data: 16'h4455, be: 2'b11});
    q0.push_back('{addr: 24'h000006, data: 16'h6600, be: 2'b10});
    applyStimulus(27'd4, 8'h11);
    applyStimulus(27'd6, 8'h22);
    checkCount++;
    if (wait0 !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL pending_wait: wait=%b with byte parked, expected 1", wait0);
    end
    applyStimulus(27'd9, 8'h33);
    applyStimulus(27'd10, 8'h44);
    applyStimulus(27'd11, 8'h55);
    applyStimulus(27'd12, 8'h66);
    setDownload(1'b0);
    while (!done0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkCount++;
    if (done0 !== 1'b1 || q0.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL back_to_back_done: done=%b pending_writes=%0d, expected done=1 pending=0",
               done0, q0.size());
    end
    ackDelay0 = 1;
  endtask

  task automatic test_base();
    int n = 0;
    idx1 = 16'h0000;
    setDownload(1'b1);
    q0.push_back('{addr: 24'h000003, data: 16'h005A, be: 2'b01});
    q1.push_back('{addr: 24'h100003, data: 16'h005A, be: 2'b01});
    applyStimulus(27'd7, 8'h5A);
    setDownload(1'b0);
    while (!(done0 && done1) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkCount++;
    if (done1 !== 1'b1 || q1.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL base_write: done=%b pending_writes=%0d, expected done=1 pending=0",
               done1, q1.size());
    end
    idx1 = 16'hFFFF;
  endtask

  task automatic test_reset_mid_req();
    int reqCnt = 0;
    ackEn0 = 1'b0;
    setDownload(1'b1);
    applyStimulus(27'h20, 8'h77);
    applyStimulus(27'h21, 8'h88);
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (req0 !== 1'b1 || wait0 !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL req_hold: req=%b wait=%b without ack, expected 1 1", req0, wait0);
    end
    #2;
    rst = 1'b1;
    #1;
    checkCount++;
    if ({req0, wait0, done0, sAddr0, sData0, sBe0} !== 45'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_mid_req: req=%b wait=%b done=%b addr=%h data=%h be=%b, expected all zero",
               req0, wait0, done0, sAddr0, sData0, sBe0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ackForce0 = 1'b1;
    @(posedge clk); #1;
    ackForce0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (req0 || wait0) reqCnt++;
    end
    @(posedge clk); #1;
    checkCount++;
    if (reqCnt !== 0) begin
      errorCount++;
      $display("[TB] FAIL spurious_ack: %0d busy cycles after stray ack, expected 0", reqCnt);
    end
    ackEn0 = 1'b1;
    setDownload(1'b0);
    @(posedge clk); #1;
  endtask

`ifdef BUBSYSROM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int n = 0;
    setDownload(1'b1);
    q0.push_back('{addr: 24'h000000, data: 16'hFF01, be: 2'b11});
    q0.push_back('{addr: 24'h000001, data: 16'h1000, be: 2'b10});
    applyStimulus(27'd0, 8'hFF);
    applyStimulus(27'd1, 8'h01);
    applyStimulus(27'd2, 8'h10);
    setDownload(1'b0);
    while (!done0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkCount++;
    if (done0 !== 1'b1 || csum0 !== 16'h0110) begin
      errorCount++;
      $display("[TB] FAIL checksum_done: done=%b checksum=%h, expected done=1 checksum=0110",
               done0, csum0);
    end
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (csum0 !== 16'h0110) begin
      errorCount++;
      $display("[TB] FAIL checksum_stable: got %h, expected 0110", csum0);
    end
  endtask
`endif

  task automatic test_drain();
    repeat (5) @(posedge clk);
    #1;
    checkCount++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drain: %0d/%0d expected writes never seen, expected 0/0",
               q0.size(), q1.size());
    end
  endtask

  initial begin
    $display("[TB] starting bubsysrom_rom_loader bench");
    test_reset();
    test_wrong_index();
    test_pair();
    test_odd_length();
    test_back_to_back();
    test_base();
    test_reset_mid_req();
`ifdef BUBSYSROM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/bubsysrom_rom_loader.md
BUBSYSROM_ROM_LOADER -- requirements
Module: bubsysrom_rom_loader

Interface
REQ-001 SHALL have parameter ROM_INDEX, default 16'h0000: ioctl_index value accepted as ROM download.
REQ-002 SHALL have parameter SDRAM_BASE, default 24'h000000: SDRAM word address of ioctl byte 0.
REQ-003 SHALL have i_EMU_MCLK  input  1  sole clock, 72 MHz; all logic on rising edge.
REQ-004 SHALL have i_EMU_INITRST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have i_IOCTL_INDEX  input  16  download image index.
REQ-006 SHALL have i_IOCTL_DOWNLOAD  input  1  download window active.
REQ-007 SHALL have i_IOCTL_ADDR  input  27  byte address.
REQ-008 SHALL have i_IOCTL_DATA  input  8  byte data.
REQ-009 SHALL have i_IOCTL_WR  input  1  one-cycle byte strobe.
REQ-010 SHALL have o_IOCTL_WAIT  output  1  stalls ioctl source.
REQ-011 SHALL have o_SDRAM_WR_REQ  output  1  write request, held until ack.
REQ-012 SHALL have o_SDRAM_ADDR  output  24  word address.
REQ-013 SHALL have o_SDRAM_DATA  output  16  write word.
REQ-014 SHALL have o_SDRAM_BE  output  2  byte enables {hi,lo}.
REQ-015 SHALL have i_SDRAM_WR_ACK  input  1  one-cycle completion from SDRAM controller.
REQ-016 SHALL have o_ROM_DOWNLOAD_DONE  output  1  ROM image fully written.

Function
REQ-017 SHALL ignore i_IOCTL_WR unless i_IOCTL_DOWNLOAD=1 and i_IOCTL_INDEX=ROM_INDEX.
REQ-018 SHALL pack big-endian (68000 order): even-address byte -> data[15:8], odd -> data[7:0].
REQ-019 SHALL form word address SDRAM_BASE + i_IOCTL_ADDR[24:1], truncated modulo 2^24.
REQ-020 SHALL run FSM IDLE, HAVE_HI, REQ, DONE.
REQ-021 IDLE: accepted even byte -> HAVE_HI (latch hi byte, address); accepted odd byte -> REQ, BE=01, hi byte 00.
REQ-022 HAVE_HI: odd byte at same word -> REQ, BE=11; even byte or odd byte at another word -> REQ flushing held byte with BE=10, new byte re-latched and handled after ack.
REQ-023 REQ: o_SDRAM_WR_REQ=1 with stable addr/data/BE until i_SDRAM_WR_ACK; on ack -> IDLE, or HAVE_HI if a re-latched byte is pending.
REQ-024 o_IOCTL_WAIT SHALL be 1 in REQ and whenever a re-latched byte is pending; source holds strobe-free while asserted.
REQ-025 Falling edge of i_IOCTL_DOWNLOAD for ROM_INDEX in HAVE_HI SHALL flush held byte (BE=10) before DONE.
REQ-026 DONE SHALL be entered once flush/pending REQ completes after download falls; o_ROM_DOWNLOAD_DONE=1 there.
REQ-027 Rising i_IOCTL_DOWNLOAD with ROM_INDEX in DONE SHALL clear o_ROM_DOWNLOAD_DONE and go IDLE.
REQ-028 Ack arriving outside REQ SHALL be ignored.
REQ-029 Latency: odd-byte strobe -> o_SDRAM_WR_REQ high on next cycle.

Reset
REQ-030 On i_EMU_INITRST=1 FSM -> IDLE; o_SDRAM_WR_REQ=0, o_IOCTL_WAIT=0, o_ROM_DOWNLOAD_DONE=0, o_SDRAM_ADDR=0, o_SDRAM_DATA=0, o_SDRAM_BE=0.
REQ-031 Reset mid-REQ SHALL drop request immediately; partial word discarded.

Configuration
REQ-032 With BUBSYSROM_LOADER_CHECKSUM_EN defined: output o_CHECKSUM (16) = modulo-2^16 sum of accepted ROM bytes, cleared on download start and reset, stable in DONE.
REQ-033 Without BUBSYSROM_LOADER_CHECKSUM_EN: port and adder absent; all other behaviour identical.

Structure
REQ-034 FSM state enum, ROM index constant and SDRAM address width SHALL live in package bubsysrom_pkg.
REQ-035 Single module; no sub-module required.

Verification
REQ-036 Bytes 0x12@0, 0x34@1, ack after 3 cycles -> one write addr 0x000000, data 0x1234, BE=11; wait high 3 cycles.
REQ-037 Odd-length image 0xAA,0xBB,0xCC then download falls -> writes 0xAABB/BE=11 @0, 0xCC00/BE=10 @1; DONE=1 after second ack.
REQ-038 Index 0x0001 traffic -> no o_SDRAM_WR_REQ, DONE stays 0.
REQ-039 SDRAM_BASE=0x100000, byte 0x5A@addr 0x7 -> write addr 0x100003, data 0x005A, BE=01.
REQ-040 Reset asserted while REQ high awaiting ack -> REQ, WAIT drop same cycle; spurious ack afterwards ignored.
REQ-041 CHECKSUM_EN build, bytes 0xFF,0x01,0x10 -> o_CHECKSUM=0x0110 in DONE.
